e603_icb_fill_master: RTL and testbench

ICB initiator that generates a programmed burst of single-word commands toward an ICB responder such as the SRAM controller/RAM top. It runs in one of two modes:
- write-fill: writes a constant or incrementing pattern.
- read-check: reads back and compares against the same pattern.

It sits beside the memory on the SoC bus for memory init and self-test, driven by a simple start/config interface, and reports completion, an error count and the first failing address.

---
 rtl/e603_icb_fill_master.sv | 170 +++++++++++++++++
 tb/tb_e603_icb_fill_master.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e603_icb_fill_master.sv
// ICB initiator that fills memory with a constant or incrementing pattern or reads it back and checks it.
// Define E603_ICB_FILL_ERRCAP_EN to enable first-error address capture (first_err_valid/first_err_addr).
module e603_icb_fill_master #(
  parameter int AW   = 12,
  parameter int DW   = 32,
  parameter int LW   = 10,
  parameter int OUTS = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            cfg_read,
  input  logic [AW-1:0]   cfg_base,
  input  logic [LW-1:0]   cfg_len,
  input  logic [DW-1:0]   cfg_pattern,
  input  logic            cfg_incr,
  output logic            busy,
  output logic            done,
  output logic [15:0]     err_cnt,
  output logic            first_err_valid,
  output logic [AW-1:0]   first_err_addr,
  output logic            icb_cmd_valid,
  input  logic            icb_cmd_ready,
  output logic            icb_cmd_read,
  output logic [AW-1:0]   icb_cmd_addr,
  output logic [DW-1:0]   icb_cmd_wdata,
  output logic [DW/8-1:0] icb_cmd_wmask,
  input  logic            icb_rsp_valid,
  output logic            icb_rsp_ready,
  input  logic [DW-1:0]   icb_rsp_rdata,
  input  logic            icb_rsp_err
);

  localparam int OW = $clog2(OUTS + 1);
  localparam logic [AW-1:0] STRIDE   = AW'(DW / 8);
  localparam logic [OW-1:0] OUTS_MAX = OW'(OUTS);

  typedef enum logic [1:0] {IDLE, CMD, DRAIN} state_t;

  state_t        state;
  logic [LW-1:0] len_q;
  logic [LW-1:0] issued;
  logic [LW-1:0] issued_nxt;
  logic [LW-1:0] rsp_cnt;
  logic          incr_q;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] out_nxt;
  logic [DW-1:0] exp_data;
  logic [DW-1:0] step;
  logic          cmd_hs;
  logic          rsp_hs;
  logic          rsp_bad;
  logic          last_rsp;
  logic          start_ok;

  assign icb_cmd_wmask = '1;
  assign icb_rsp_ready = 1'b1;

  // Responses outside an operation are swallowed without touching any counter.
  assign start_ok   = (state == IDLE) && start;
  assign cmd_hs     = icb_cmd_valid && icb_cmd_ready;
  assign rsp_hs     = icb_rsp_valid && (state != IDLE);
  assign step       = DW'(incr_q);
  assign issued_nxt = issued + LW'(cmd_hs);
  assign rsp_bad    = icb_rsp_err || (icb_cmd_read && (icb_rsp_rdata != exp_data));
  assign last_rsp   = rsp_hs && (rsp_cnt == len_q - LW'(1));

  always_comb begin
    out_nxt = outstanding;
    if (cmd_hs && !rsp_hs)
      out_nxt = outstanding + OW'(1);
    else if (!cmd_hs && rsp_hs)
      out_nxt = outstanding - OW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_cnt       <= '0;
      len_q         <= '0;
      incr_q        <= 1'b0;
      issued        <= '0;
      rsp_cnt       <= '0;
      outstanding   <= '0;
      exp_data      <= '0;
      icb_cmd_valid <= 1'b0;
      icb_cmd_read  <= 1'b0;
      icb_cmd_addr  <= '0;
      icb_cmd_wdata <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            icb_cmd_read  <= cfg_read;
            len_q         <= cfg_len;
            incr_q        <= cfg_incr;
            icb_cmd_addr  <= cfg_base;
            icb_cmd_wdata <= cfg_pattern;
            exp_data      <= cfg_pattern;
            issued        <= '0;
            rsp_cnt       <= '0;
            outstanding   <= '0;
            err_cnt       <= '0;
            if (cfg_len != '0) begin
              state         <= CMD;
              busy          <= 1'b1;
              icb_cmd_valid <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        default: begin
          outstanding <= out_nxt;
          issued      <= issued_nxt;
          // Address/data only advance on a handshake, so they stay stable under backpressure.
          if (cmd_hs) begin
            icb_cmd_addr  <= icb_cmd_addr + STRIDE;
            icb_cmd_wdata <= icb_cmd_wdata + step;
          end
          icb_cmd_valid <= (state == CMD) && (issued_nxt < len_q) && (out_nxt < OUTS_MAX);
          if ((state == CMD) && cmd_hs && (issued_nxt == len_q))
            state <= DRAIN;
          if (rsp_hs) begin
            rsp_cnt  <= rsp_cnt + LW'(1);
            exp_data <= exp_data + step;
            if (rsp_bad && (err_cnt != 16'hFFFF))
              err_cnt <= err_cnt + 16'd1;
          end
          if (last_rsp) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b1;
            icb_cmd_valid <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef E603_ICB_FILL_ERRCAP_EN
  logic [AW-1:0] exp_addr;

  // Tracks the address of the word each response belongs to and latches the first bad one.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_addr        <= '0;
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
    end else if (start_ok) begin
      exp_addr        <= cfg_base;
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
    end else if (rsp_hs) begin
      exp_addr <= exp_addr + STRIDE;
      if (rsp_bad && !first_err_valid) begin
        first_err_valid <= 1'b1;
        first_err_addr  <= exp_addr;
      end
    end
  end
`else
  assign first_err_valid = 1'b0;
  assign first_err_addr  = '0;
`endif

endmodule

// File: tb/tb_e603_icb_fill_master.sv
// Scoreboard bench for e603_icb_fill_master: a 1-cycle ICB RAM responder with stall, hold-off and error injection.
module tb_e603_icb_fill_master;

  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int LW   = 10;
  localparam int OUTS = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            cfg_read;
  logic [AW-1:0]   cfg_base;
  logic [LW-1:0]   cfg_len;
  logic [DW-1:0]   cfg_pattern;
  logic            cfg_incr;
  logic            busy;
  logic            done;
  logic [15:0]     err_cnt;
  logic            first_err_valid;
  logic [AW-1:0]   first_err_addr;
  logic            icb_cmd_valid;
  logic            icb_cmd_ready;
  logic            icb_cmd_read;
  logic [AW-1:0]   icb_cmd_addr;
  logic [DW-1:0]   icb_cmd_wdata;
  logic [DW/8-1:0] icb_cmd_wmask;
  logic            icb_rsp_valid;
  logic            icb_rsp_ready;
  logic [DW-1:0]   icb_rsp_rdata;
  logic            icb_rsp_err;

  typedef struct packed {
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  typedef struct packed {
    logic [15:0]   ec;
    logic          fev;
    logic [AW-1:0] fea;
  } done_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
  } pend_t;

  cmd_t  cmd_q[$];
  done_t done_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  logic hold_rsp     = 1'b0;
  int   stall_word   = -1;
  int   stall_cycles = 0;
  int   err_at       = -1;

  e603_icb_fill_master dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .cfg_read        (cfg_read),
    .cfg_base        (cfg_base),
    .cfg_len         (cfg_len),
    .cfg_pattern     (cfg_pattern),
    .cfg_incr        (cfg_incr),
    .busy            (busy),
    .done            (done),
    .err_cnt         (err_cnt),
    .first_err_valid (first_err_valid),
    .first_err_addr  (first_err_addr),
    .icb_cmd_valid   (icb_cmd_valid),
    .icb_cmd_ready   (icb_cmd_ready),
    .icb_cmd_read    (icb_cmd_read),
    .icb_cmd_addr    (icb_cmd_addr),
    .icb_cmd_wdata   (icb_cmd_wdata),
    .icb_cmd_wmask   (icb_cmd_wmask),
    .icb_rsp_valid   (icb_rsp_valid),
    .icb_rsp_ready   (icb_rsp_ready),
    .icb_rsp_rdata   (icb_rsp_rdata),
    .icb_rsp_err     (icb_rsp_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_busy"},      32'(busy), 32'd0);
    checkOutput({tag, "_done"},      32'(done), 32'd0);
    checkOutput({tag, "_err_cnt"},   32'(err_cnt), 32'd0);
    checkOutput({tag, "_fev"},       32'(first_err_valid), 32'd0);
    checkOutput({tag, "_fea"},       32'(first_err_addr), 32'd0);
    checkOutput({tag, "_cmd_valid"}, 32'(icb_cmd_valid), 32'd0);
    checkOutput({tag, "_cmd_read"},  32'(icb_cmd_read), 32'd0);
    checkOutput({tag, "_cmd_addr"},  32'(icb_cmd_addr), 32'd0);
    checkOutput({tag, "_cmd_wdata"}, 32'(icb_cmd_wdata), 32'd0);
    checkOutput({tag, "_rsp_ready"}, 32'(icb_rsp_ready), 32'd1);
  endtask

  task automatic pushCmds(input logic rd, input logic [AW-1:0] base, input int len,
                          input logic [DW-1:0] pat, input logic incr);
    cmd_t c;
    for (int i = 0; i < len; i++) begin
      c.rd   = rd;
      c.addr = base + AW'(i * 4);
      c.data = pat + (incr ? DW'(i) : DW'(0));
      cmd_q.push_back(c);
    end
  endtask

  // One complete operation: expectations go to the scoreboard, then start is pulsed and done awaited.
  task automatic applyStimulus(input logic rd, input logic [AW-1:0] base, input int len,
                               input logic [DW-1:0] pat, input logic incr,
                               input int exp_ec, input logic [AW-1:0] exp_fea, input int hold);
    done_t d;
    bit    got;
    pushCmds(rd, base, len, pat, incr);
    d.ec = 16'(exp_ec);
`ifdef E603_ICB_FILL_ERRCAP_EN
    d.fev = (exp_ec != 0);
    d.fea = exp_fea;
`else
    d.fev = 1'b0;
    d.fea = '0;
`endif
    done_q.push_back(d);
    @(negedge clk);
    cfg_read    = rd;
    cfg_base    = base;
    cfg_len     = LW'(len);
    cfg_pattern = pat;
    cfg_incr    = incr;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (len == 0) begin
      checkOutput("zero_len_done", 32'(done), 32'd1);
      checkOutput("zero_len_busy", 32'(busy), 32'd0);
      checkOutput("zero_len_valid", 32'(icb_cmd_valid), 32'd0);
      @(negedge clk);
      checkOutput("zero_len_done_off", 32'(done), 32'd0);
      checkOutput("zero_len_valid_off", 32'(icb_cmd_valid), 32'd0);
      return;
    end
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    checkOutput("valid_after_start", 32'(icb_cmd_valid), 32'd1);
    checkOutput("first_addr", 32'(icb_cmd_addr), 32'(base));
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      checkOutput("hold_no_third_cmd", 32'(icb_cmd_valid), 32'd0);
      checkOutput("hold_busy", 32'(busy), 32'd1);
      hold_rsp = 1'b0;
    end
    got = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      #2;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL done_timeout: got no done, expected done within 300 cycles");
    end
  endtask

  // RAM responder: accepts commands, answers in order one cycle later unless held off.
  initial begin
    logic [DW-1:0] mem [0:1023];
    pend_t         pend[$];
    pend_t         p;
    bit            rst_e, start_e, cmd_hs_r, rsp_hs_r, hs_read;
    logic [AW-1:0] hs_addr;
    logic [DW-1:0] hs_wdata;
    int            cmd_idx, stall_left;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    cmd_idx       = 0;
    stall_left    = 0;
    cmd_hs_r      = 1'b0;
    rsp_hs_r      = 1'b0;
    hs_read       = 1'b0;
    hs_addr       = '0;
    hs_wdata      = '0;
    icb_cmd_ready = 1'b1;
    icb_rsp_valid = 1'b0;
    icb_rsp_rdata = '0;
    icb_rsp_err   = 1'b0;
    forever begin
      @(posedge clk);
      rst_e   = rst;
      start_e = start;
      @(negedge clk);
      if (rst_e) begin
        pend.delete();
        cmd_idx  = 0;
        cmd_hs_r = 1'b0;
        rsp_hs_r = 1'b0;
      end else begin
        if (rsp_hs_r && pend.size() > 0) void'(pend.pop_front());
        if (cmd_hs_r) begin
          p.err = (cmd_idx == err_at);
          if (hs_read) begin
            p.data = mem[hs_addr[AW-1:2]];
          end else begin
            mem[hs_addr[AW-1:2]] = hs_wdata;
            p.data = '0;
          end
          pend.push_back(p);
          cmd_idx++;
        end
        if (start_e) begin
          cmd_idx    = 0;
          stall_left = stall_cycles;
        end
      end
      icb_rsp_valid = (pend.size() > 0) && !hold_rsp;
      icb_rsp_rdata = icb_rsp_valid ? pend[0].data : '0;
      icb_rsp_err   = icb_rsp_valid ? pend[0].err : 1'b0;
      icb_cmd_ready = !((cmd_idx == stall_word) && (stall_left > 0));
      if (icb_cmd_valid && !icb_cmd_ready) stall_left--;
      cmd_hs_r = icb_cmd_valid && icb_cmd_ready;
      hs_read  = icb_cmd_read;
      hs_addr  = icb_cmd_addr;
      hs_wdata = icb_cmd_wdata;
      rsp_hs_r = icb_rsp_valid;
    end
  end

  // Monitor: pops the scoreboard on every command handshake and every done pulse.
  initial begin
    int            out_cnt;
    bit            prev_stall, prev_done;
    logic [AW-1:0] sa;
    logic [DW-1:0] sd;
    cmd_t          c;
    done_t         d;
    out_cnt    = 0;
    prev_stall = 1'b0;
    prev_done  = 1'b0;
    sa         = '0;
    sd         = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        out_cnt    = 0;
        prev_stall = 1'b0;
        prev_done  = 1'b0;
        continue;
      end
      if (prev_stall) begin
        checkOutput("stall_addr_stable", 32'(icb_cmd_addr), 32'(sa));
        checkOutput("stall_wdata_stable", icb_cmd_wdata, sd);
      end
      prev_stall = icb_cmd_valid && !icb_cmd_ready;
      sa = icb_cmd_addr;
      sd = icb_cmd_wdata;
      if (out_cnt >= OUTS)
        checkOutput("outstanding_limit", 32'(icb_cmd_valid), 32'd0);
      if (icb_cmd_valid && icb_cmd_ready) begin
        if (cmd_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL unexpected_cmd: got cmd addr 0x%0h, expected none", icb_cmd_addr);
        end else begin
          c = cmd_q.pop_front();
          checkOutput("cmd_addr", 32'(icb_cmd_addr), 32'(c.addr));
          checkOutput("cmd_wdata", icb_cmd_wdata, c.data);
          checkOutput("cmd_read", 32'(icb_cmd_read), 32'(c.rd));
          checkOutput("cmd_wmask", 32'(icb_cmd_wmask), 32'hF);
        end
        out_cnt++;
      end
      if (icb_rsp_valid) out_cnt--;
      if (done) begin
        checkOutput("done_single_pulse", 32'(prev_done), 32'd0);
        checkOutput("done_busy_low", 32'(busy), 32'd0);
        if (done_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL unexpected_done: got done, expected none");
        end else begin
          d = done_q.pop_front();
          checkOutput("err_cnt", 32'(err_cnt), 32'(d.ec));
          checkOutput("first_err_valid", 32'(first_err_valid), 32'(d.fev));
          checkOutput("first_err_addr", 32'(first_err_addr), 32'(d.fea));
        end
      end
      prev_done = done;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "[TB] global timeout");
  end

  // Directed test sequence.
  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    cfg_read    = 1'b0;
    cfg_base    = '0;
    cfg_len     = '0;
    cfg_pattern = '0;
    cfg_incr    = 1'b0;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst = 1'b0;

    applyStimulus(1'b0, 12'h100, 4, 32'hA5A5_0000, 1'b1, 0, 12'h000, 0);
    applyStimulus(1'b1, 12'h100, 4, 32'hA5A5_0000, 1'b1, 0, 12'h000, 0);
    applyStimulus(1'b0, 12'h108, 1, 32'h0000_0000, 1'b0, 0, 12'h000, 0);
    applyStimulus(1'b1, 12'h100, 4, 32'hA5A5_0000, 1'b1, 1, 12'h108, 0);
    applyStimulus(1'b0, 12'h500, 0, 32'h1234_5678, 1'b0, 0, 12'h000, 0);

    stall_word   = 1;
    stall_cycles = 3;
    applyStimulus(1'b0, 12'h200, 4, 32'h1122_3344, 1'b0, 0, 12'h000, 0);
    stall_word   = -1;
    stall_cycles = 0;

    hold_rsp = 1'b1;
    applyStimulus(1'b0, 12'h300, 4, 32'h0000_0005, 1'b1, 0, 12'h000, 6);

    err_at = 2;
    applyStimulus(1'b0, 12'h100, 4, 32'hA5A5_0000, 1'b1, 1, 12'h108, 0);
    err_at = -1;

    applyStimulus(1'b0, 12'hFF8, 4, 32'hFFFF_FFFF, 1'b1, 0, 12'h000, 0);
    applyStimulus(1'b1, 12'hFF8, 4, 32'hFFFF_FFFF, 1'b1, 0, 12'h000, 0);
    applyStimulus(1'b1, 12'h300, 4, 32'h0000_0005, 1'b0, 3, 12'h304, 0);

    pushCmds(1'b0, 12'h400, 8, 32'h0000_0077, 1'b0);
    @(negedge clk);
    cfg_read    = 1'b0;
    cfg_base    = 12'h400;
    cfg_len     = 10'd8;
    cfg_pattern = 32'h0000_0077;
    cfg_incr    = 1'b0;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkResetValues("midreset");
    cmd_q.delete();

    applyStimulus(1'b1, 12'h100, 4, 32'hA5A5_0000, 1'b1, 0, 12'h000, 0);

    repeat (3) @(negedge clk);
    checkOutput("cmd_queue_drained", 32'(cmd_q.size()), 32'd0);
    checkOutput("done_queue_drained", 32'(done_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
